// File: rtl/seg7_scan_bcd.sv
// rtl/seg7_scan_bcd.sv - BCD-converting, time-multiplexed common-anode 7-segment driver
//
// Purpose:
//   Accepts an unsigned binary value over a valid/ready handshake, converts it
//   to BCD with a sequential double-dabble engine (one bit per cycle), and
//   scans DIGITS active-low common-anode digits. It blanks leading zeros and
//   shows dashes on overflow.
//
// Optional feature macro: SEG7_UNIT_SUFFIX_EN
//   When defined, digit 0 shows 'C' and digit 1 shows a degree sign. The
//   number then occupies digits 2..DIGITS-1.
//
// Ports:
//   clk_100MHz  in   1       system clock
//   rst_n       in   1       asynchronous active-low reset
//   data_in     in   DATA_W  unsigned value to display
//   data_valid  in   1       data_in valid
//   data_ready  out  1       converter idle, value can be accepted
//   SEG         out  7       segments, active-low, bit6 = a .. bit0 = g
//   AN          out  DIGITS  anodes, active-low, AN[0] = rightmost digit

module seg7_scan_bcd #(
  parameter int DATA_W   = 8,
  parameter int DIGITS   = 4,
  parameter int CLK_HZ   = 100_000_000,
  parameter int DIGIT_HZ = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk_100MHz,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [6:0]        SEG,
  output logic [DIGITS-1:0] AN
);

  localparam int DWELL = CLK_HZ / DIGIT_HZ;
  localparam int TMR_W = $clog2(DWELL);
  localparam int IDX_W = $clog2(DIGITS);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef SEG7_UNIT_SUFFIX_EN
  localparam int OFF = 2;
`else
  localparam int OFF = 0;
`endif
  localparam int NUM_N = DIGITS - OFF;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  state_t             state_q, state_d;
  logic               alive_q;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic               ovf_q, ovf_d, shift_out;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   disp_bcd_q, disp_bcd_d;
  logic               disp_ovf_q, disp_ovf_d;
  logic [TMR_W-1:0]   tmr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [6:0]         seg_q, seg_d;
  logic [DIGITS-1:0]  an_q, an_d;

  function automatic logic [6:0] seg_lut(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_lut = 7'b0000001;
      4'd1:    seg_lut = 7'b1001111;
      4'd2:    seg_lut = 7'b0010010;
      4'd3:    seg_lut = 7'b0000110;
      4'd4:    seg_lut = 7'b1001100;
      4'd5:    seg_lut = 7'b0100100;
      4'd6:    seg_lut = 7'b0100000;
      4'd7:    seg_lut = 7'b0001111;
      4'd8:    seg_lut = 7'b0000000;
      4'd9:    seg_lut = 7'b0000100;
      default: seg_lut = 7'h7F;
    endcase
  endfunction

  // alive_q keeps data_ready low while reset is asserted and for no longer.
  assign data_ready = alive_q && (state_q == S_IDLE);
  assign SEG        = seg_q;
  assign AN         = an_q;

  // Converter next state
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    disp_bcd_d = disp_bcd_q;
    disp_ovf_d = disp_ovf_q;
    shift_out  = 1'b0;
    bcd_adj    = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      S_IDLE: begin
        if (data_valid && data_ready) begin
          shift_d = data_in;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        // A bit leaving the top nibble means the value needs more digits
        // than exist; remember it until the next accept.
        {shift_out, bcd_d, shift_d} = {bcd_adj, shift_q, 1'b0};
        ovf_d = ovf_q | shift_out;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_LOAD;
      end
      S_LOAD: begin
        disp_bcd_d = bcd_q;
        disp_ovf_d = ovf_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Digit decode for the slot selected by idx_q
  logic               disp_overflow, upper_nz, blank;
  logic [IDX_W-1:0]   num_k;
  logic [3:0]         num_nib;

  always_comb begin
    disp_overflow = disp_ovf_q;
    for (int j = NUM_N; j < DIGITS; j++) begin
      if (disp_bcd_q[4*j +: 4] != 4'd0) disp_overflow = 1'b1;
    end
    // num_k wraps for suffix slots; those slots are overridden below.
    num_k    = idx_q - IDX_W'(OFF);
    num_nib  = 4'd0;
    upper_nz = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (j == int'(num_k)) num_nib = disp_bcd_q[4*j +: 4];
      if (j >= int'(num_k) && j < NUM_N && disp_bcd_q[4*j +: 4] != 4'd0) upper_nz = 1'b1;
    end
    blank = (BLANK_LZ != 0) && !disp_overflow && (num_k != '0) && !upper_nz;

    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = disp_overflow ? SEG_DASH : seg_lut(num_nib);
    if (blank) begin
      an_d  = '1;
      seg_d = SEG_OFF;
    end
`ifdef SEG7_UNIT_SUFFIX_EN
    if (idx_q == IDX_W'(0)) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = 7'b0110001;
    end else if (idx_q == IDX_W'(1)) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = 7'b0011100;
    end
`endif
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      alive_q    <= 1'b0;
      shift_q    <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
      tmr_q      <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_OFF;
      an_q       <= '1;
    end else begin
      state_q    <= state_d;
      alive_q    <= 1'b1;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      disp_bcd_q <= disp_bcd_d;
      disp_ovf_q <= disp_ovf_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      if (tmr_q == TMR_W'(DWELL - 1)) begin
        tmr_q <= '0;
        idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        tmr_q <= tmr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_bcd.sv
// tb/tb_seg7_scan_bcd.sv - directed self-checking bench for seg7_scan_bcd

module tb_seg7_scan_bcd;

`ifdef SEG7_UNIT_SUFFIX_EN
  localparam int C_DIG = 4;
`else
  localparam int C_DIG = 2;
`endif

  localparam logic [6:0] P0    = 7'b0000001;
  localparam logic [6:0] P2    = 7'b0010010;
  localparam logic [6:0] P4    = 7'b1001100;
  localparam logic [6:0] P5    = 7'b0100100;
  localparam logic [6:0] P7    = 7'b0001111;
  localparam logic [6:0] PDASH = 7'b1111110;
  localparam logic [6:0] POFF  = 7'h7F;
`ifdef SEG7_UNIT_SUFFIX_EN
  localparam logic [6:0] P3    = 7'b0000110;
  localparam logic [6:0] PC    = 7'b0110001;
  localparam logic [6:0] PDEG  = 7'b0011100;
  localparam logic [6:0] SLOT0 = PC;
`else
  localparam logic [6:0] SLOT0 = P0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [7:0]       data;
  logic             va, vb, vc;
  logic             ra, rb, rc;
  logic [6:0]       seg_a, seg_b, seg_c;
  logic [3:0]       an_a, an_b;
  logic [C_DIG-1:0] an_c;
  logic [3:0]       an_c4;

  int checks = 0;
  int fails  = 0;

  always_comb begin
    an_c4 = '1;
    an_c4[C_DIG-1:0] = an_c;
  end

  seg7_scan_bcd #(.DATA_W(8), .DIGITS(4), .CLK_HZ(4000), .DIGIT_HZ(1000), .BLANK_LZ(1)) u_a (
    .clk_100MHz(clk), .rst_n(rst_n), .data_in(data), .data_valid(va),
    .data_ready(ra), .SEG(seg_a), .AN(an_a));

  seg7_scan_bcd #(.DATA_W(8), .DIGITS(4), .CLK_HZ(4000), .DIGIT_HZ(1000), .BLANK_LZ(0)) u_b (
    .clk_100MHz(clk), .rst_n(rst_n), .data_in(data), .data_valid(vb),
    .data_ready(rb), .SEG(seg_b), .AN(an_b));

  seg7_scan_bcd #(.DATA_W(8), .DIGITS(C_DIG), .CLK_HZ(4000), .DIGIT_HZ(1000), .BLANK_LZ(1)) u_c (
    .clk_100MHz(clk), .rst_n(rst_n), .data_in(data), .data_valid(vc),
    .data_ready(rc), .SEG(seg_c), .AN(an_c));

  function automatic logic get_ready(input int which);
    case (which)
      0:       return ra;
      1:       return rb;
      default: return rc;
    endcase
  endfunction

  task automatic sample(input int which, output logic [3:0] an, output logic [6:0] seg);
    case (which)
      0:       begin an = an_a;  seg = seg_a; end
      1:       begin an = an_b;  seg = seg_b; end
      default: begin an = an_c4; seg = seg_c; end
    endcase
  endtask

  task automatic set_valid(input int which, input logic v);
    case (which)
      0:       va = v;
      1:       vb = v;
      default: vc = v;
    endcase
  endtask

  // Waits (bounded) for data_ready, then presents v for exactly one cycle.
  task automatic send(input int which, input logic [7:0] v);
    int n = 0;
    @(negedge clk);
    while (get_ready(which) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      fails++;
      $display("FAIL send_wait_ready dut%0d: data_ready=%b, required 1 within 50 cycles", which, get_ready(which));
    end
    data = v;
    set_valid(which, 1'b1);
    @(posedge clk);
    #1 set_valid(which, 1'b0);
  endtask

  // Observes 16 consecutive cycles and checks every slot against the
  // expected digit patterns; lit[d]=0 means digit d must be blanked.
  task automatic check_frame(input int which, input string name,
                             input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0,
                             input logic [3:0] lit, input int exp_blanks);
    logic [6:0] exp_s [4];
    logic [3:0] seen;
    logic [3:0] an;
    logic [6:0] seg;
    int         blanks;
    bit         found;
    exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2; exp_s[3] = e3;
    seen   = '0;
    blanks = 0;
    repeat (16) begin
      @(negedge clk);
      sample(which, an, seg);
      if (an === 4'hF) begin
        blanks++;
        checks++;
        if (seg !== POFF) begin
          fails++;
          $display("FAIL %s blank_seg: SEG=%b, required %b", name, seg, POFF);
        end
      end else begin
        found = 1'b0;
        for (int d = 0; d < 4; d++) begin
          if (an === ~(4'b0001 << d)) begin
            found   = 1'b1;
            seen[d] = 1'b1;
            checks++;
            if (!lit[d] || seg !== exp_s[d]) begin
              fails++;
              $display("FAIL %s digit%0d: lit=%b SEG=%b, required lit=%b SEG=%b",
                       name, d, 1'b1, seg, lit[d], exp_s[d]);
            end
          end
        end
        checks++;
        if (!found) begin
          fails++;
          $display("FAIL %s anode: AN=%b, required one-hot-low or all ones", name, an);
        end
      end
    end
    checks++;
    if (seen !== lit) begin
      fails++;
      $display("FAIL %s lit_set: lit=%b, required %b", name, seen, lit);
    end
    checks++;
    if (blanks != exp_blanks) begin
      fails++;
      $display("FAIL %s blank_count: %0d, required %0d", name, blanks, exp_blanks);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data = '0; va = 1'b0; vb = 1'b0; vc = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (seg_a !== POFF) begin fails++; $display("FAIL reset_seg: SEG=%b, required %b", seg_a, POFF); end
    checks++;
    if (an_a !== 4'hF) begin fails++; $display("FAIL reset_an: AN=%b, required 1111", an_a); end
    checks++;
    if (ra !== 1'b0) begin fails++; $display("FAIL reset_ready: data_ready=%b, required 0", ra); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ra !== 1'b1) begin fails++; $display("FAIL release_ready: data_ready=%b, required 1", ra); end
    checks++;
    if (an_a !== 4'b1110) begin fails++; $display("FAIL release_an: AN=%b, required 1110", an_a); end
    checks++;
    if (seg_a !== SLOT0) begin fails++; $display("FAIL release_seg: SEG=%b, required %b", seg_a, SLOT0); end
`ifndef SEG7_UNIT_SUFFIX_EN
    check_frame(0, "reset_frame", POFF, POFF, POFF, P0, 4'b0001, 12);
`endif
  endtask

  task automatic test_ready_latency();
    send(0, 8'd255);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checks++;
      if (ra !== 1'b0) begin fails++; $display("FAIL busy_ready cycle%0d: data_ready=%b, required 0", i, ra); end
    end
    @(negedge clk);
    checks++;
    if (ra !== 1'b1) begin fails++; $display("FAIL ready_return: data_ready=%b, required 1", ra); end
    repeat (2) @(negedge clk);
    check_frame(0, "show_255", POFF, P2, P5, P5, 4'b0111, 4);
  endtask

  task automatic test_busy_ignore();
    send(0, 8'd42);
    repeat (2) @(negedge clk);
    checks++;
    if (ra !== 1'b0) begin fails++; $display("FAIL busy_during_conv: data_ready=%b, required 0", ra); end
    data = 8'd7;
    va = 1'b1;
    @(posedge clk);
    #1 va = 1'b0;
    repeat (12) @(negedge clk);
    check_frame(0, "show_42", POFF, POFF, P4, P2, 4'b0011, 8);
    send(0, 8'd7);
    repeat (12) @(negedge clk);
    check_frame(0, "show_7", POFF, POFF, POFF, P7, 4'b0001, 12);
  endtask

  task automatic test_no_blank();
    send(1, 8'd5);
    repeat (12) @(negedge clk);
    check_frame(1, "noblank_5", P0, P0, P0, P5, 4'b1111, 0);
  endtask

  task automatic test_overflow();
    send(2, 8'd200);
    repeat (12) @(negedge clk);
    check_frame(2, "ovf_200", POFF, POFF, PDASH, PDASH, 4'b0011, 0);
  endtask

  task automatic test_scan_timing();
    logic [3:0] prev;
    int         n = 0;
    bit         synced = 1'b0;
    prev = an_b;
    while (n < 40 && !synced) begin
      @(negedge clk);
      if (prev === 4'b0111 && an_b === 4'b1110) synced = 1'b1;
      prev = an_b;
      n++;
    end
    checks++;
    if (!synced) begin
      fails++;
      $display("FAIL scan_sync: AN=%b, required a 0111->1110 transition within 40 cycles", an_b);
    end
    for (int k = 0; k < 17; k++) begin
      logic [3:0] exp_an;
      if (k > 0) @(negedge clk);
      exp_an = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (an_b !== exp_an) begin
        fails++;
        $display("FAIL scan_step%0d: AN=%b, required %b", k, an_b, exp_an);
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    send(0, 8'd42);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (seg_a !== POFF) begin fails++; $display("FAIL midconv_seg: SEG=%b, required %b", seg_a, POFF); end
    checks++;
    if (an_a !== 4'hF) begin fails++; $display("FAIL midconv_an: AN=%b, required 1111", an_a); end
    checks++;
    if (ra !== 1'b0) begin fails++; $display("FAIL midconv_ready: data_ready=%b, required 0", ra); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_frame(0, "after_abort", POFF, POFF, POFF, P0, 4'b0001, 12);
  endtask

`ifdef SEG7_UNIT_SUFFIX_EN
  task automatic test_suffix();
    send(0, 8'd23);
    repeat (12) @(negedge clk);
    check_frame(0, "suffix_23", P2, P3, PDEG, PC, 4'b1111, 0);
  endtask
`endif

  initial begin
    test_reset();
`ifdef SEG7_UNIT_SUFFIX_EN
    test_suffix();
`else
    test_ready_latency();
    test_busy_ignore();
    test_no_blank();
    test_overflow();
    test_scan_timing();
    test_reset_mid_conv();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
